// File: rtl/step_conditioner_pkg.sv
// Shared types and constants for the step conditioner.
// Debouncer state encoding and debounce lengths.
package cond_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } deb_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/step_conditioner_debouncer.sv
// Level debouncer with registered rising-edge pulse.
// A new level must hold DEBOUNCE_CYCLES cycles to be accepted.
module debouncer
  import cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // State, counter and pulse registers; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Qualification: any disagreeing sample drops back to the idle state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (din) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!din) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!din) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (din) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign level      = (state_q == IDLE_HIGH) ||
                      (state_q == WAIT_LOW);
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/step_conditioner.sv
// Button/switch conditioner feeding the sequence detectors.
// Optional macro SW_DEBOUNCE_EN also debounces the switch.
module step_conditioner
  import cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic sw,
  output logic step,
  output logic w,
  output logic btn_level
);

  logic btn_m, btn_s;
  logic sw_m, sw_s;

  // Two-flop synchronizers: the only entry for the raw inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= 1'b0;
      sw_s  <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      sw_m  <= sw;
      sw_s  <= sw_m;
    end
  end

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_deb (
    .clk       (clk),
    .reset     (reset),
    .din       (btn_s),
    .level     (btn_level),
    .rise_pulse(step)
  );

`ifdef SW_DEBOUNCE_EN
  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_deb (
    .clk       (clk),
    .reset     (reset),
    .din       (sw_s),
    .level     (w),
    .rise_pulse()
  );
`else
  logic w_q;

  // Register the synchronized switch so w and step both come from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= 1'b0;
    end else begin
      w_q <= sw_s;
    end
  end

  assign w = w_q;
`endif

endmodule

// File: tb/tb_step_conditioner.sv
// Directed bench for step_conditioner, DEBOUNCE_CYCLES=4.
// Inputs change #1 after an edge; outputs are checked there.
module tb_step_conditioner;
  import cond_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0;
  logic sw = 1'b0;
  logic step, w, btn_level;

  int n_pass = 0;
  int n_total = 0;
  int n_edge = 0;
  int n_steps;

  step_conditioner #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .sw       (sw),
    .step     (step),
    .w        (w),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n_edge++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               tag, got, exp, n_edge);
    else
      n_pass++;
  endtask

  initial begin
    bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_step", step, 0);
      chk("rst_w", w, 0);
      chk("rst_lvl", btn_level, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_step", step, 0);
    end

    // clean press: step and level after edge k+5
    btn = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      chk("press_step", step, (j == 6));
      chk("press_lvl", btn_level, (j >= 6));
    end

    // release: no pulse, level drops after k+5
    btn = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("rel_step", step, 0);
      chk("rel_lvl", btn_level, (j < 6));
    end

    // bounce 1,0,1,1,0 then held
    for (int i = 0; i < 5; i++) begin
      btn = pat[i];
      tick();
      chk("bounce_step", step, 0);
      chk("bounce_lvl", btn_level, 0);
    end
    btn = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("bounce_hold_step", step, (j == 6));
    end

    // release then re-press twice: two pulses total
    btn = 1'b0;
    for (int j = 1; j <= 10; j++) tick();
    chk("pre_rp_lvl", btn_level, 0);
    n_steps = 0;
    for (int r = 0; r < 2; r++) begin
      btn = 1'b1;
      for (int j = 1; j <= 10; j++) begin
        tick();
        if (step) n_steps++;
        chk("rp_press_step", step, (j == 6));
      end
      btn = 1'b0;
      for (int j = 1; j <= 10; j++) begin
        tick();
        if (step) n_steps++;
        chk("rp_rel_step", step, 0);
      end
    end
    chk("rp_count", n_steps, 2);

    // reset on the edge where step would fire
    btn = 1'b1;
    for (int j = 1; j <= 5; j++) tick();
    chk("pre_rst_step", step, 0);
    reset = 1'b1;
    tick();
    chk("midrst_step", step, 0);
    chk("midrst_lvl", btn_level, 0);
    reset = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("post_rst_step", step, (j == 6));
      chk("post_rst_lvl", btn_level, (j >= 6));
    end
    btn = 1'b0;
    for (int j = 1; j <= 8; j++) tick();

    // switch path
    chk("sw_init", w, 0);
    sw = 1'b1;
`ifdef SW_DEBOUNCE_EN
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("sw_rise", w, (j >= 6));
    end
    sw = 1'b0;
    tick();
    tick();
    sw = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("sw_glitch", w, 1);
    end
`else
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("sw_rise", w, (j >= 3));
    end
    sw = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("sw_fall", w, (j < 3));
    end
`endif
    chk("sw_no_step", step, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
